// File: rtl/sdram_ctrl_arb.sv
// sdram_ctrl_arb: round-robin I/D arbiter sequencing a fixed
// 9-cycle SDRAM transaction (line fill, word read, word/byte write).
module sdram_ctrl_arb (
    input  logic        MCLK,
    input  logic        Reset,
    input  logic        I_Req,
    input  logic [31:0] I_Addr,
    output logic        I_Grant,
    output logic        I_RValid,
    output logic [31:0] I_RData,
    output logic [1:0]  I_WordIdx,
    output logic        I_Done,
    input  logic        D_Req,
    input  logic        D_Wr,
    input  logic        D_Byte,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_WData,
    output logic        D_Grant,
    output logic        D_RValid,
    output logic [31:0] D_RData,
    output logic        D_Done,
    output logic [31:0] Addr,
    inout  wire  [31:0] Data,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nWE,
    output logic        nCS,
    output logic        SEQ,
    output logic        BYTE
);

    typedef enum logic [1:0] {IDLE, ACT, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cyc_q, cyc_d;
    logic        lg_q, lg_d;
    logic        port_q, port_d;
    logic        wr_q, wr_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        arb;

    logic        i_grant_q, i_grant_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [1:0]  i_idx_q, i_idx_d;
    logic        i_done_q, i_done_d;
    logic        d_grant_q, d_grant_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_done_q, d_done_d;
    logic [31:0] a_q, a_d;
    logic        nras_q, nras_d;
    logic        ncas_q, ncas_d;
    logic        nwe_q, nwe_d;
    logic        ncs_q, ncs_d;
    logic        seq_q, seq_d;
    logic        bo_q, bo_d;
    logic        oe_q, oe_d;
    logic [31:0] dout_q, dout_d;
    logic        act_d, rd_slot, last;
    logic [1:0]  widx;

    // State, cycle counter and latched transaction registers
    always_ff @(posedge MCLK) begin
        if (Reset) begin
            state_q <= IDLE;
            cyc_q   <= 4'd0;
            lg_q    <= 1'b0;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            lg_q    <= lg_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: arbitrate when idle or at the last cycle of a run
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        lg_d    = lg_q;
        port_d  = port_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        arb     = 1'b0;
        unique case (state_q)
            IDLE: arb = I_Req | D_Req;
            ACT: begin
                state_d = RUN;
                cyc_d   = 4'd1;
            end
            RUN: begin
                if (cyc_q != 4'd8) begin
                    cyc_d = cyc_q + 4'd1;
                end else begin
                    arb = I_Req | D_Req;
                    if (!arb) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (arb) begin
            state_d = ACT;
            cyc_d   = 4'd0;
            port_d  = D_Req & (~I_Req | ~lg_q);
            lg_d    = port_d;
            addr_d  = port_d ? D_Addr : I_Addr;
            wr_d    = port_d & D_Wr;
            byte_d  = port_d & D_Wr & D_Byte;
            if (port_d) wdata_d = D_WData;
        end
    end

    // Output next values: pins for the coming cycle, returns for the ending one
    always_comb begin
        act_d     = (state_d != IDLE);
        i_grant_d = (state_d == ACT) & ~port_d;
        d_grant_d = (state_d == ACT) & port_d;
        nras_d    = ~(state_d == ACT);
        ncs_d     = ~act_d;
        nwe_d     = ~(act_d & wr_d);
        a_d       = act_d ? addr_d : a_q;
        bo_d      = act_d & byte_d;
        ncas_d    = ~(act_d & (cyc_d == (wr_d ? 4'd4 : 4'd3)));
        seq_d     = act_d & ~wr_d & (cyc_d >= 4'd5);
        oe_d      = act_d & wr_d & (cyc_d >= 4'd1) & (cyc_d <= 4'd4);
        dout_d    = byte_d ? {4{wdata_d[7:0]}} : wdata_d;
        rd_slot   = (state_q == RUN) & ~wr_q & (cyc_q >= 4'd5);
        widx      = cyc_q[1:0] - 2'd1;
        last      = (state_q == RUN) & (cyc_q == 4'd8);
        i_rvalid_d = rd_slot & ~port_q;
        i_rdata_d  = i_rvalid_d ? Data : i_rdata_q;
        i_idx_d    = i_rvalid_d ? widx : i_idx_q;
        d_rvalid_d = rd_slot & port_q & (widx == addr_q[3:2]);
        d_rdata_d  = d_rvalid_d ? Data : d_rdata_q;
        i_done_d   = last & ~port_q;
        d_done_d   = last & port_q;
    end

    // Output registers
    always_ff @(posedge MCLK) begin
        if (Reset) begin
            i_grant_q  <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'd0;
            i_idx_q    <= 2'd0;
            i_done_q   <= 1'b0;
            d_grant_q  <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_done_q   <= 1'b0;
            a_q        <= 32'd0;
            nras_q     <= 1'b1;
            ncas_q     <= 1'b1;
            nwe_q      <= 1'b1;
            ncs_q      <= 1'b1;
            seq_q      <= 1'b0;
            bo_q       <= 1'b0;
            oe_q       <= 1'b0;
            dout_q     <= 32'd0;
        end else begin
            i_grant_q  <= i_grant_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_idx_q    <= i_idx_d;
            i_done_q   <= i_done_d;
            d_grant_q  <= d_grant_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_done_q   <= d_done_d;
            a_q        <= a_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            nwe_q      <= nwe_d;
            ncs_q      <= ncs_d;
            seq_q      <= seq_d;
            bo_q       <= bo_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    assign Data      = oe_q ? dout_q : {32{1'bz}};
    assign I_Grant   = i_grant_q;
    assign I_RValid  = i_rvalid_q;
    assign I_RData   = i_rdata_q;
    assign I_WordIdx = i_idx_q;
    assign I_Done    = i_done_q;
    assign D_Grant   = d_grant_q;
    assign D_RValid  = d_rvalid_q;
    assign D_RData   = d_rdata_q;
    assign D_Done    = d_done_q;
    assign Addr      = a_q;
    assign nRAS      = nras_q;
    assign nCAS      = ncas_q;
    assign nWE       = nwe_q;
    assign nCS       = ncs_q;
    assign SEQ       = seq_q;
    assign BYTE      = bo_q;

endmodule

// File: tb/tb_sdram_ctrl_arb.sv
// tb_sdram_ctrl_arb: directed and random transactions against a
// behavioural SDRAM and a word-level reference memory.
module tb_sdram_ctrl_arb;

    logic        MCLK = 1'b0;
    logic        Reset;
    logic        I_Req;
    logic [31:0] I_Addr;
    logic        I_Grant, I_RValid, I_Done;
    logic [31:0] I_RData;
    logic [1:0]  I_WordIdx;
    logic        D_Req, D_Wr, D_Byte;
    logic [31:0] D_Addr, D_WData;
    logic        D_Grant, D_RValid, D_Done;
    logic [31:0] D_RData;
    logic [31:0] Addr;
    wire  [31:0] Data;
    logic        nRAS, nCAS, nWE, nCS, SEQ, BYTE;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] ref_mem [0:1023];
    bit last_d;

    sdram_ctrl_arb dut (
        .MCLK(MCLK), .Reset(Reset),
        .I_Req(I_Req), .I_Addr(I_Addr), .I_Grant(I_Grant),
        .I_RValid(I_RValid), .I_RData(I_RData),
        .I_WordIdx(I_WordIdx), .I_Done(I_Done),
        .D_Req(D_Req), .D_Wr(D_Wr), .D_Byte(D_Byte),
        .D_Addr(D_Addr), .D_WData(D_WData), .D_Grant(D_Grant),
        .D_RValid(D_RValid), .D_RData(D_RData), .D_Done(D_Done),
        .Addr(Addr), .Data(Data), .nRAS(nRAS), .nCAS(nCAS),
        .nWE(nWE), .nCS(nCS), .SEQ(SEQ), .BYTE(BYTE)
    );

    always #5 MCLK = ~MCLK;

    // Behavioural SDRAM: counts cycles from the row strobe
    logic [31:0] mem [0:1023];
    logic [3:0]  m_cyc = 4'd9;
    logic [31:0] m_addr = 32'd0;
    logic        m_we = 1'b1;
    logic [1:0]  m_w;
    assign m_w  = 2'(m_cyc - 4'd5);
    assign Data = (!m_we && m_cyc >= 4'd5 && m_cyc <= 4'd8) ?
                  mem[{m_addr[11:4], m_w}] : {32{1'bz}};

    always @(posedge MCLK) begin
        if (!nCS && !nRAS) begin
            m_cyc  <= 4'd1;
            m_addr <= Addr;
            m_we   <= !nWE;
        end else if (m_cyc < 4'd9) begin
            m_cyc <= m_cyc + 4'd1;
        end
        if (!nCS && !nCAS && m_we) begin
            if (BYTE)
                mem[m_addr[11:2]][m_addr[1:0]*8 +: 8] <= Data[m_addr[1:0]*8 +: 8];
            else
                mem[m_addr[11:2]] <= Data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {26'd0, nRAS, nCAS, nWE, nCS, SEQ, BYTE},
            32'b111100);
        chk({tag, "_addr"}, Addr, 32'd0);
        chk({tag, "_resp"}, {26'd0, I_Grant, I_RValid, I_Done,
                             D_Grant, D_RValid, D_Done}, 32'd0);
    endtask

    task automatic wait_grant(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge MCLK);
            ok = is_d ? D_Grant : I_Grant;
        end
        chk(is_d ? "d_grant_wait" : "i_grant_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_txn(input bit is_d, input bit wr, input bit byt,
                          input logic [31:0] a, input logic [31:0] wd);
        bit ok, ew, eb;
        logic [31:0] line [4];
        logic [31:0] drv;
        int idx;
        ew  = is_d && wr;
        eb  = ew && byt;
        drv = eb ? {4{wd[7:0]}} : wd;
        for (int k = 0; k < 4; k++)
            line[k] = ref_mem[{a[11:4], 2'(k)}];
        if (is_d) begin
            D_Req = 1; D_Wr = wr; D_Byte = byt; D_Addr = a; D_WData = wd;
        end else begin
            I_Req = 1; I_Addr = a;
        end
        wait_grant(is_d, ok);
        I_Req = 0;
        D_Req = 0;
        if (!ok) return;
        last_d = is_d;
        chk("c0_nRAS", {31'd0, nRAS}, 32'd0);
        chk("c0_nCS", {31'd0, nCS}, 32'd0);
        chk("c0_nWE", {31'd0, nWE}, {31'd0, !ew});
        chk("c0_addr", is_d ? Addr : {Addr[31:4], 4'h0},
            is_d ? a : {a[31:4], 4'h0});
        chk("c0_other_grant", {31'd0, is_d ? I_Grant : D_Grant}, 32'd0);
        I_Addr  = $urandom;
        D_Addr  = $urandom;
        D_WData = $urandom;
        D_Wr    = 1'($urandom);
        D_Byte  = 1'($urandom);
        for (int n = 1; n <= 9; n++) begin
            @(negedge MCLK);
            idx = n - 6;
            if (n <= 8) begin
                chk("nRAS", {31'd0, nRAS}, 32'd1);
                chk("nCS", {31'd0, nCS}, 32'd0);
                chk("addr_hold", Addr[31:4], {4'd0, a[31:4]});
                chk("BYTE", {31'd0, BYTE}, {31'd0, eb});
                chk("nCAS", {31'd0, nCAS},
                    (n == (ew ? 4 : 3)) ? 32'd0 : 32'd1);
                chk("SEQ", {31'd0, SEQ}, {31'd0, !ew && n >= 5});
                if (ew && n <= 4) chk("wdata", Data, drv);
            end
            if (is_d) begin
                chk("d_rvalid", {31'd0, D_RValid},
                    {31'd0, !ew && n >= 6 && idx == int'(a[3:2])});
                if (!ew && n >= 6 && idx == int'(a[3:2]))
                    chk("d_rdata", D_RData, line[idx]);
            end else begin
                chk("i_rvalid", {31'd0, I_RValid}, {31'd0, n >= 6});
                if (n >= 6) begin
                    chk("i_idx", {30'd0, I_WordIdx}, 32'(idx));
                    chk("i_rdata", I_RData, line[idx]);
                end
            end
            chk("done", {31'd0, is_d ? D_Done : I_Done}, {31'd0, n == 9});
        end
        if (ew) begin
            if (eb) ref_mem[a[11:2]][a[1:0]*8 +: 8] = wd[7:0];
            else    ref_mem[a[11:2]] = wd;
        end
    endtask

    initial begin
        int g, t, last_t;
        bit ok;
        Reset = 1; I_Req = 0; I_Addr = 0;
        D_Req = 0; D_Wr = 0; D_Byte = 0; D_Addr = 0; D_WData = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        last_d = 0;
        repeat (10) @(negedge MCLK);
        chk_reset("por");
        Reset = 0;

        do_txn(1, 1, 0, 32'h100, 32'h11);
        do_txn(1, 1, 0, 32'h104, 32'h22);
        do_txn(1, 1, 0, 32'h108, 32'h33);
        do_txn(1, 1, 0, 32'h10C, 32'h44);
        do_txn(1, 1, 0, 32'h300, 32'h11223344);
        do_txn(0, 0, 0, 32'h108, 32'h0);

        I_Req = 1; I_Addr = 32'h104;
        D_Req = 1; D_Wr = 0; D_Byte = 0; D_Addr = 32'h108;
        g = 0; t = 0; last_t = 0;
        while (g < 4 && t < 80) begin
            @(negedge MCLK);
            t++;
            if (I_Grant || D_Grant) begin
                chk("arb_winner", {31'd0, D_Grant}, {31'd0, !last_d});
                chk("arb_single", {31'd0, I_Grant && D_Grant}, 32'd0);
                if (g > 0) chk("arb_gap", t - last_t, 32'd9);
                last_d = !last_d;
                last_t = t;
                g++;
                if (g == 4) begin I_Req = 0; D_Req = 0; end
            end
        end
        chk("arb_count", g, 32'd4);
        I_Req = 0;
        D_Req = 0;
        repeat (10) @(negedge MCLK);

        do_txn(1, 1, 0, 32'h200, 32'hDEADBEEF);
        do_txn(1, 0, 0, 32'h200, 32'h0);
        do_txn(1, 1, 1, 32'h302, 32'h000000AB);
        do_txn(1, 0, 0, 32'h300, 32'h0);
        chk("byte_merge_ref", ref_mem[32'h300 >> 2], 32'h11AB3344);
        do_txn(1, 0, 1, 32'h10C, 32'h0);

        I_Req = 1; I_Addr = 32'h100;
        wait_grant(0, ok);
        I_Req = 0;
        if (ok) begin
            repeat (5) @(negedge MCLK);
            Reset = 1;
            @(negedge MCLK);
            chk_reset("abort");
            for (int i = 0; i < 8; i++) begin
                @(negedge MCLK);
                chk("abort_nodone", {30'd0, I_Done, I_RValid}, 32'd0);
            end
        end
        Reset = 0;
        last_d = 0;
        do_txn(0, 0, 0, 32'h100, 32'h0);

        for (int i = 0; i < 16; i++)
            do_txn(1, 1, 0, 32'h400 + 32'(i * 4), $urandom);
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   32'h400 + 32'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge MCLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
